// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register write-back arbiter for pipeline and multi-cycle results
// Buffered multi-cycle results compete with the pipeline for one registered write port.
module reg_wb_arbiter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    input  logic        i_mdu_valid,
    input  logic [4:0]  i_mdu_rd,
    input  logic [31:0] i_mdu_data,
    output logic        o_mdu_ready,
    output logic        o_reg_write,
    output logic [4:0]  o_write_rd,
    output logic [31:0] o_write_data,
    output logic        o_stall,
    output logic [31:0] o_busy
);

    logic [4:0]  fifo_rd   [2];
    logic [31:0] fifo_data [2];
    logic        head;
    logic [1:0]  count;
    logic [1:0]  starve;

    logic        fifo_ne;
    logic        alu_ok;
    logic        push;
    logic        sel_fifo;
    logic        sel_alu;
    logic        tail;

    always_comb begin
        fifo_ne     = (count != 2'd0);
        o_mdu_ready = !i_rst && (count != 2'd2);
        o_stall     = !i_rst && ((count == 2'd2) || (starve == 2'd3));
        alu_ok      = i_alu_valid && (i_alu_rd != 5'd0);
        // rd==0 results are acknowledged but dropped here
        push        = i_mdu_valid && o_mdu_ready && (i_mdu_rd != 5'd0);
        sel_fifo    = fifo_ne && (o_stall || !alu_ok);
        sel_alu     = !o_stall && alu_ok;
        tail        = head ^ count[0];
    end

    always_comb begin
        o_busy = '0;
        if (!i_rst) begin
            if (count != 2'd0) o_busy[fifo_rd[head]] = 1'b1;
            if (count == 2'd2) o_busy[fifo_rd[~head]] = 1'b1;
        end
    end

    // Storage is qualified by count/head, so it needs no reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            fifo_rd[tail]   <= i_mdu_rd;
            fifo_data[tail] <= i_mdu_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head         <= 1'b0;
            count        <= 2'd0;
            starve       <= 2'd0;
            o_reg_write  <= 1'b0;
            o_write_rd   <= 5'd0;
            o_write_data <= 32'd0;
        end else begin
            head  <= head ^ sel_fifo;
            count <= count + {1'b0, push} - {1'b0, sel_fifo};
            if (sel_fifo || !fifo_ne)
                starve <= 2'd0;
            else if (sel_alu && (starve != 2'd3))
                starve <= starve + 2'd1;
            o_reg_write <= sel_fifo || sel_alu;
            if (sel_fifo) begin
                o_write_rd   <= fifo_rd[head];
                o_write_data <= fifo_data[head];
            end else if (sel_alu) begin
                o_write_rd   <= i_alu_rd;
                o_write_data <= i_alu_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed scoreboard bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_mdu_valid;
    logic [4:0]  i_mdu_rd;
    logic [31:0] i_mdu_data;
    logic        o_mdu_ready;
    logic        o_reg_write;
    logic [4:0]  o_write_rd;
    logic [31:0] o_write_data;
    logic        o_stall;
    logic [31:0] o_busy;

    reg_wb_arbiter dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_alu_valid  (i_alu_valid),
        .i_alu_rd     (i_alu_rd),
        .i_alu_data   (i_alu_data),
        .i_mdu_valid  (i_mdu_valid),
        .i_mdu_rd     (i_mdu_rd),
        .i_mdu_data   (i_mdu_data),
        .o_mdu_ready  (o_mdu_ready),
        .o_reg_write  (o_reg_write),
        .o_write_rd   (o_write_rd),
        .o_write_data (o_write_data),
        .o_stall      (o_stall),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [4:0]  hold_rd = 5'd0;
    logic [31:0] hold_data = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check state-derived outputs before the edge,
    // queue the expected write port value and compare it after the edge.
    task automatic cyc(input string tag, input logic rst,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic rdy, input logic stl, input logic [31:0] bsy,
                       input logic ewe, input logic [4:0] erd, input logic [31:0] ed);
        wr_t e;
        i_rst       = rst;
        i_alu_valid = av;
        i_alu_rd    = ard;
        i_alu_data  = ad;
        i_mdu_valid = mv;
        i_mdu_rd    = mrd;
        i_mdu_data  = md;
        if (rst) begin
            hold_rd   = 5'd0;
            hold_data = 32'd0;
        end else if (ewe) begin
            hold_rd   = erd;
            hold_data = ed;
        end
        exp_q.push_back({(ewe && !rst), hold_rd, hold_data});
        #1;
        chk({tag, ".ready"}, 32'(o_mdu_ready), 32'(rdy));
        chk({tag, ".stall"}, 32'(o_stall), 32'(stl));
        chk({tag, ".busy"},  o_busy, bsy);
        @(posedge i_clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".we"},   32'(o_reg_write), 32'(e.we));
            chk({tag, ".rd"},   32'(o_write_rd), 32'(e.rd));
            chk({tag, ".data"}, o_write_data, e.data);
        end
    endtask

    initial begin
        // reset, with a handshake presented that must be discarded
        cyc("rst0", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc("rst1", 1'b1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);

        // pipeline only
        cyc("alu",  1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        cyc("hold", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);

        // single mdu result on an idle pipeline: written two cycles after acceptance
        cyc("mdu_t0", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc("mdu_t1", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h80, 1'b1, 5'd7, 32'h12);
        cyc("mdu_t2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);

        // rd==0 from both sources
        cyc("rd0_a", 1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc("rd0_b", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);

        // buffer fills while the pipeline writes rd1 every cycle, then starvation on rd4
        cyc("full1", 1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 32'h0, 1'b1, 5'd1, 32'hA1);
        cyc("full2", 1'b0, 1'b1, 5'd1, 32'hA2, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 32'h8, 1'b1, 5'd1, 32'hA2);
        cyc("full3", 1'b0, 1'b1, 5'd1, 32'hA3, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1, 32'h18, 1'b1, 5'd3, 32'h33);
        cyc("full4", 1'b0, 1'b1, 5'd1, 32'hA4, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, 5'd1, 32'hA4);
        cyc("full5", 1'b0, 1'b1, 5'd1, 32'hA5, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, 5'd1, 32'hA5);
        cyc("full6", 1'b0, 1'b1, 5'd1, 32'hA6, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, 5'd1, 32'hA6);
        cyc("full7", 1'b0, 1'b1, 5'd1, 32'hA7, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 5'd4, 32'h44);

        // starvation of a single rd9 entry
        cyc("stv1", 1'b0, 1'b1, 5'd2, 32'hB1, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 32'h0, 1'b1, 5'd2, 32'hB1);
        cyc("stv2", 1'b0, 1'b1, 5'd2, 32'hB2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h200, 1'b1, 5'd2, 32'hB2);
        cyc("stv3", 1'b0, 1'b1, 5'd2, 32'hB3, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h200, 1'b1, 5'd2, 32'hB3);
        cyc("stv4", 1'b0, 1'b1, 5'd2, 32'hB4, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h200, 1'b1, 5'd2, 32'hB4);
        cyc("stv5", 1'b0, 1'b1, 5'd2, 32'hB5, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b1, 5'd9, 32'h99);
        cyc("stv6", 1'b0, 1'b1, 5'd2, 32'hB6, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 5'd2, 32'hB6);

        // same-cycle push and pop at count 1, then rd0 pipeline lets the buffer issue
        cyc("pp1", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc("pp2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hB0, 1'b1, 1'b0, 32'h400, 1'b1, 5'd10, 32'hA0);
        cyc("pp3", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h800, 1'b1, 5'd11, 32'hB0);
        cyc("pp4", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc("pp5", 1'b0, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h1000, 1'b1, 5'd12, 32'hC0);
        cyc("pp6", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);

        // reset with two buffered entries discards them
        cyc("rr1", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hD0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc("rr2", 1'b0, 1'b1, 5'd3, 32'hD2, 1'b1, 5'd14, 32'hE0, 1'b1, 1'b0, 32'h2000, 1'b1, 5'd3, 32'hD2);
        cyc("rr3", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'hF0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc("rr4", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc("rr5", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc("rr6", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
